// File: rtl/mul_mac.sv
// -----------------------------------------------------------------------------
// mul_mac -- sequencing front-end and accumulator for the 8x8 add-shift
// sequential multiplier.
//
// Accepts 8-bit operand pairs over a valid/ready handshake, issues each pair to
// the external multiplier with a one-cycle start pulse, waits for the
// multiplier's done flag and adds the 16-bit product into an ACC_W-bit
// accumulator. After the pair flagged as last has been accumulated, the sum is
// presented over a valid/ready output handshake and cleared when consumed.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds its payload stable while
// valid is high and ready is low. in_ready is high only in IDLE. acc_valid is
// high only in OUT, and acc_ready has no effect anywhere else.
//
// Optional feature macro: MUL_MAC_SAT_EN
//   defined   -> on carry out the accumulator saturates to all-ones and stays
//                there until the sum is consumed.
//   undefined -> the accumulator wraps modulo 2^ACC_W.
//   acc_ovf is set on carry out in both builds.
//
// Parameters:
//   ACC_W      accumulator width in bits, legal range 16..32 (default 24)
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      pair can be accepted (IDLE only)
//   in_a       in   8      multiplicand
//   in_b       in   8      multiplier
//   in_last    in   1      pair is the final term of the current sum
//   mul_a      out  8      operand A to multiplier, held from accept to accept
//   mul_b      out  8      operand B to multiplier, same timing as mul_a
//   mul_start  out  1      one-cycle start pulse to multiplier
//   mul_c      in   16     multiplier product
//   mul_done   in   1      multiplier idle/finished flag (high when idle)
//   acc_valid  out  1      accumulated sum valid
//   acc_ready  in   1      consumer accepts sum
//   acc        out  ACC_W  accumulated sum
//   acc_ovf    out  1      sticky carry-out flag for the current sum
// -----------------------------------------------------------------------------
module mul_mac #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    output logic             mul_start,
    input  logic [15:0]      mul_c,
    input  logic             mul_done,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    logic   last_r;

    // One extra bit on the sum captures the carry out of the accumulator.
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    assign sum_ext = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, mul_c};
    assign carry   = sum_ext[ACC_W];

`ifdef MUL_MAC_SAT_EN
    // Once saturated, any further add carries again, so all-ones is sticky.
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            last_r    <= 1'b0;
            mul_a     <= 8'd0;
            mul_b     <= 8'd0;
            mul_start <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a     <= in_a;
                        mul_b     <= in_b;
                        last_r    <= in_last;
                        mul_start <= 1'b1;
                        state     <= S_START;
                    end
                end

                // The multiplier still reports idle during this cycle, so
                // mul_done is deliberately not looked at here.
                S_START: begin
                    mul_start <= 1'b0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (mul_done) begin
                        acc     <= acc_next;
                        acc_ovf <= acc_ovf | carry;
                        if (last_r) begin
                            acc_valid <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_OUT: begin
                    if (acc_ready) begin
                        acc       <= '0;
                        acc_ovf   <= 1'b0;
                        acc_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
